// File: rtl/dualport_ram_pkg.sv
// Shared types, collision-mode constants and byte-merge helper for the dual-port RAM.
package dualport_ram_pkg;

  typedef enum logic {CLR, IDLE} state_t;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MAX_W = 512;

  function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0]   old_w,
                                                  input logic [MAX_W-1:0]   new_w,
                                                  input logic [MAX_W/8-1:0] be);
    logic [MAX_W-1:0] r;
    for (int k = 0; k < MAX_W/8; k++)
      r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dualport_ram_rdpipe.sv
// Read result pipeline: STAGES registers of data plus a valid shift register.
module dualport_ram_rdpipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid
);

  logic [STAGES:1]            vld_pipe;
  logic [STAGES:1][WIDTH-1:0] dat_pipe;

  // Data stages only load behind a valid, so the last stage holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      if (in_valid) dat_pipe[1] <= in_data;
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign data_out = dat_pipe[STAGES];
  assign rd_valid = vld_pipe[STAGES];

endmodule

// File: rtl/dualport_ram_bec.sv
// One-write/one-read RAM with byte enables, selectable collision mode,
// configurable read latency and a background clear engine.
module dualport_ram_bec #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  output logic               busy,
  input  logic               write,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               read,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  output logic               addr_err
);
  import dualport_ram_pkg::*;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              wr_in_rng, rd_in_rng;
  logic              wr_en, rd_en, wr_oor, rd_oor, collide;
  logic [WIDTH-1:0]  wr_merged, rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // A clear request during the sweep is dropped rather than restarting it.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      CLR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      IDLE: if (clear) begin
        state_nxt = CLR;
        ptr_nxt   = '0;
      end
      default: state_nxt = CLR;
    endcase
  end

  assign busy      = (state == CLR);
  assign wr_in_rng = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in_rng = {1'b0, rd_addr} < DEPTH_X;
  assign wr_en     = !busy && write && wr_in_rng;
  assign wr_oor    = !busy && write && !wr_in_rng;
  assign rd_en     = !busy && read;
  assign rd_oor    = !busy && read && !rd_in_rng;
  assign collide   = wr_en && (wr_addr == rd_addr);

  assign wr_merged = WIDTH'(byte_merge(MAX_W'(mem[wr_addr]), MAX_W'(data_in),
                                       (MAX_W/8)'(wr_be)));

  // Out-of-range reads still return a (zero) result so the valid count matches requests.
  always_comb begin
    rd_word = '0;
    if (rd_in_rng) begin
      if (WRITE_FIRST == dualport_ram_pkg::WRITE_FIRST && collide) rd_word = wr_merged;
      else                                                         rd_word = mem[rd_addr];
    end
  end

  // Array has no reset; the clear engine owns zeroing it.
  always_ff @(posedge clk) begin
    if (busy)       mem[ptr]     <= '0;
    else if (wr_en) mem[wr_addr] <= wr_merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  addr_err <= 1'b0;
    else if (!busy && clear)  addr_err <= 1'b0;
    else if (wr_oor || rd_oor) addr_err <= 1'b1;
  end

  dualport_ram_rdpipe #(
    .WIDTH  (WIDTH),
    .STAGES (RD_LATENCY)
  ) u_rdpipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_data  (rd_word),
    .data_out (data_out),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_dualport_ram_bec.sv
// Drives three RAM configurations in lockstep against a behavioural model and read scoreboard.
module tb_dualport_ram_bec;

  localparam int N = 3;

  // k=0: DEPTH16 lat1 read-first; k=1: DEPTH16 lat2 write-first; k=2: DEPTH12 lat1 read-first
  function automatic int dep(input int k); return (k == 2) ? 12 : 16; endfunction
  function automatic int lat(input int k); return (k == 1) ? 2 : 1;   endfunction
  function automatic int wf(input int k);  return (k == 1) ? 1 : 0;   endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    merge = {be[1] ? n[15:8] : o[15:8], be[0] ? n[7:0] : o[7:0]};
  endfunction

  typedef struct packed {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clear, write, read;
  logic [3:0]  wr_addr, rd_addr;
  logic [1:0]  wr_be;
  logic [15:0] data_in;

  logic [15:0] dout [N];
  logic        vld  [N];
  logic        bsy  [N];
  logic        aerr [N];

  logic [15:0] mm     [N][16];
  int          clr_left [N];
  logic        aerr_m [N];
  logic [15:0] last_m [N];
  exp_t        q [N][$];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dualport_ram_bec #(.WIDTH(16), .DEPTH(16), .RD_LATENCY(1), .WRITE_FIRST(0)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .busy(bsy[0]), .write(write), .wr_addr(wr_addr),
    .wr_be(wr_be), .data_in(data_in), .read(read), .rd_addr(rd_addr), .data_out(dout[0]),
    .rd_valid(vld[0]), .addr_err(aerr[0]));

  dualport_ram_bec #(.WIDTH(16), .DEPTH(16), .RD_LATENCY(2), .WRITE_FIRST(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .busy(bsy[1]), .write(write), .wr_addr(wr_addr),
    .wr_be(wr_be), .data_in(data_in), .read(read), .rd_addr(rd_addr), .data_out(dout[1]),
    .rd_valid(vld[1]), .addr_err(aerr[1]));

  dualport_ram_bec #(.WIDTH(16), .DEPTH(12), .RD_LATENCY(1), .WRITE_FIRST(0)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .busy(bsy[2]), .write(write), .wr_addr(wr_addr),
    .wr_be(wr_be), .data_in(data_in), .read(read), .rd_addr(rd_addr), .data_out(dout[2]),
    .rd_valid(vld[2]), .addr_err(aerr[2]));

  // One clock: apply inputs, update model at the edge, then compare outputs 1ns later.
  task automatic step(input logic w, input logic [3:0] wa, input logic [1:0] be,
                      input logic [15:0] din, input logic r, input logic [3:0] ra,
                      input logic c);
    exp_t e;
    write = w; wr_addr = wa; wr_be = be; data_in = din;
    read = r; rd_addr = ra; clear = c;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (clr_left[k] > 0) begin
        mm[k][dep(k) - clr_left[k]] = '0;
        clr_left[k]--;
      end else begin
        if (r) begin
          e.cyc = cyc;
          if (int'(ra) >= dep(k)) begin
            e.data = '0;
            aerr_m[k] = 1'b1;
          end else if (wf(k) == 1 && w && wa == ra) e.data = merge(mm[k][ra], din, be);
          else e.data = mm[k][ra];
          q[k].push_back(e);
        end
        if (w) begin
          if (int'(wa) >= dep(k)) aerr_m[k] = 1'b1;
          else mm[k][wa] = merge(mm[k][wa], din, be);
        end
        if (c) begin
          clr_left[k] = dep(k);
          aerr_m[k]   = 1'b0;
        end
      end
    end
    #1;
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (bsy[k] !== (clr_left[k] > 0))
        $display("FAIL busy[%0d] cyc %0d: got %b want %b", k, cyc, bsy[k], clr_left[k] > 0);
      else n_pass++;
      n_chk++;
      if (aerr[k] !== aerr_m[k])
        $display("FAIL addr_err[%0d] cyc %0d: got %b want %b", k, cyc, aerr[k], aerr_m[k]);
      else n_pass++;
      if (vld[k] === 1'b1) begin
        n_chk++;
        if (q[k].size() == 0)
          $display("FAIL spurious_valid[%0d] cyc %0d: got 1 want 0", k, cyc);
        else begin
          e = q[k].pop_front();
          if (cyc != e.cyc + lat(k) - 1 || dout[k] !== e.data)
            $display("FAIL read[%0d] cyc %0d: got %h@%0d want %h@%0d", k, cyc, dout[k], cyc,
                     e.data, e.cyc + lat(k) - 1);
          else n_pass++;
          last_m[k] = e.data;
        end
      end else begin
        n_chk++;
        if (vld[k] !== 1'b0) $display("FAIL rd_valid[%0d] cyc %0d: got %b want 0", k, cyc, vld[k]);
        else n_pass++;
        if (q[k].size() > 0 && cyc >= q[k][0].cyc + lat(k) - 1) begin
          n_chk++;
          $display("FAIL missing_valid[%0d] cyc %0d: got 0 want 1", k, cyc);
          void'(q[k].pop_front());
        end
        n_chk++;
        if (dout[k] !== last_m[k])
          $display("FAIL hold[%0d] cyc %0d: got %h want %h", k, cyc, dout[k], last_m[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset(input int hold);
    write = 0; read = 0; clear = 0; wr_addr = 0; rd_addr = 0; wr_be = 0; data_in = 0;
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (dout[k] !== 16'h0 || vld[k] !== 1'b0 || aerr[k] !== 1'b0 || bsy[k] !== 1'b1)
        $display("FAIL reset[%0d]: got dout=%h vld=%b aerr=%b busy=%b want 0/0/0/1",
                 k, dout[k], vld[k], aerr[k], bsy[k]);
      else n_pass++;
      clr_left[k] = dep(k);
      aerr_m[k]   = 1'b0;
      last_m[k]   = '0;
      q[k].delete();
    end
    repeat (hold) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Counts busy samples from now on; the first sample is the current one.
  task automatic test_busy_len();
    int cnt [N];
    for (int k = 0; k < N; k++) cnt[k] = (bsy[k] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 24; i++) begin
      idle(1);
      for (int k = 0; k < N; k++) if (bsy[k] === 1'b1) cnt[k]++;
    end
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (cnt[k] != dep(k)) $display("FAIL busy_len[%0d]: got %0d want %0d", k, cnt[k], dep(k));
      else n_pass++;
    end
  endtask

  task automatic test_read_all();
    for (int a = 0; a < 16; a++) step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(a), 1'b0);
    idle(3);
  endtask

  task automatic test_byte_merge();
    step(1'b1, 4'd3, 2'b11, 16'hBEEF, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd3, 2'b01, 16'h0012, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'b00, 16'h0,    1'b1, 4'd3, 1'b0);
    n_chk++;
    if (dout[0] !== 16'hBE12) $display("FAIL byte_merge lat1: got %h want be12", dout[0]);
    else n_pass++;
    idle(1);
    n_chk++;
    if (dout[1] !== 16'hBE12) $display("FAIL byte_merge lat2: got %h want be12", dout[1]);
    else n_pass++;
  endtask

  task automatic test_collision();
    step(1'b1, 4'd5, 2'b11, 16'h1111, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd5, 2'b11, 16'h2222, 1'b1, 4'd5, 1'b0);
    n_chk++;
    if (dout[0] !== 16'h1111) $display("FAIL collision read_first: got %h want 1111", dout[0]);
    else n_pass++;
    idle(1);
    n_chk++;
    if (dout[1] !== 16'h2222) $display("FAIL collision write_first: got %h want 2222", dout[1]);
    else n_pass++;
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd5, 1'b0);
    n_chk++;
    if (dout[0] !== 16'h2222) $display("FAIL collision reread: got %h want 2222", dout[0]);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_out_of_range();
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
    idle(17);
    step(1'b1, 4'd13, 2'b11, 16'h7777, 1'b0, 4'd0, 1'b0);
    n_chk++;
    if (aerr[2] !== 1'b1 || aerr[0] !== 1'b0)
      $display("FAIL oor_write addr_err: got %b/%b want 1/0", aerr[2], aerr[0]);
    else n_pass++;
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd13, 1'b0);
    n_chk++;
    if (vld[2] !== 1'b1 || dout[2] !== 16'h0 || dout[0] !== 16'h7777)
      $display("FAIL oor_read: got vld=%b d=%h d0=%h want 1/0000/7777", vld[2], dout[2], dout[0]);
    else n_pass++;
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd1, 1'b0);
    idle(4);
    n_chk++;
    if (aerr[2] !== 1'b1) $display("FAIL oor_sticky: got %b want 1", aerr[2]);
    else n_pass++;
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
    n_chk++;
    if (aerr[2] !== 1'b0) $display("FAIL oor_clear: got %b want 0", aerr[2]);
    else n_pass++;
    idle(17);
  endtask

  task automatic test_clear_fill();
    int cnt;
    for (int a = 0; a < 16; a++) step(1'b1, 4'(a), 2'b11, 16'hA5A5, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
    cnt = (bsy[0] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 4)      step(1'b1, 4'd2, 2'b11, 16'h1234, 1'b0, 4'd0, 1'b0);
      else if (i == 6) step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'd4, 1'b0);
      else if (i == 8) step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
      else             idle(1);
      if (bsy[0] === 1'b1) cnt++;
    end
    n_chk++;
    if (cnt != 16) $display("FAIL clear_busy_len: got %0d want 16", cnt);
    else n_pass++;
    test_read_all();
  endtask

  task automatic test_rst_mid_clear();
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
    idle(7);
    test_reset(1);
    test_busy_len();
  endtask

  task automatic test_back_to_back();
    logic [7:0] h0, h1;
    for (int a = 0; a < 4; a++) step(1'b1, 4'(a), 2'b11, 16'h1000 + 16'(a), 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, 4'(i), 1'b0);
      else       idle(1);
      h0[i] = vld[0];
      h1[i] = vld[1];
    end
    n_chk++;
    if (h1 !== 8'b0001_1110) $display("FAIL b2b_lat2_pulses: got %b want 00011110", h1);
    else n_pass++;
    n_chk++;
    if (h0 !== 8'b0000_1111) $display("FAIL b2b_lat1_pulses: got %b want 00001111", h0);
    else n_pass++;
    n_chk++;
    if (dout[1] !== 16'h1003) $display("FAIL b2b_last: got %h want 1003", dout[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 63) == 0));
    idle(20);
  endtask

  initial begin
    rst = 1'b0;
    #2;
    test_reset(2);
    test_busy_len();
    test_read_all();
    test_byte_merge();
    test_collision();
    test_out_of_range();
    test_clear_fill();
    test_rst_mid_clear();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
